// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, S-box, Rcon, FSM states.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned RND_W      = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Forward S-box, entry 0 in the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte substitution through the forward S-box.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for schedule rounds 1..10; zero outside that range.
  function automatic logic [7:0] rcon(input logic [RND_W-1:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One combinational AES-128 key-schedule round: current round key -> next round key.
module aes_key_round
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_in,
  output logic [127:0] key_out
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot_w3;
  logic [WORD_W-1:0] sub_w3;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  // RotWord: cyclic left rotate by one byte.
  assign rot_w3 = {w3[23:0], w3[31:24]};

  // SubWord on each byte of the rotated word.
  assign sub_w3 = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                   sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};

  // Chained word XORs forming the next round key.
  assign n0 = w0 ^ sub_w3 ^ {rcon_in, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_dec_key_gen.sv
// Iterative AES-128 key expansion producing the round-10 key for the decryption core.
// One shared round instance is stepped once per cycle; fixed 10-cycle latency.
module aes_dec_key_gen #(
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid_in,
  input  logic [127:0] key_in,
  output logic         busy_out,
  output logic         key_valid_out,
  output logic [127:0] dec_key_out
);

  localparam int unsigned RND_W = aes_pkg::RND_W;
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS);
  localparam logic [RND_W-1:0] FIRST_ROUND = RND_W'(1);

  aes_pkg::state_e   state_q, state_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic [127:0]      work_key_q, work_key_d;
  logic [127:0]      dec_key_d;
  logic              key_valid_d;
  logic [127:0]      round_key;
  logic [7:0]        round_rcon;

  assign round_rcon = aes_pkg::rcon(round_q);

  // Single schedule round reused on every BUSY cycle.
  aes_key_round u_round (
    .key_in  (work_key_q),
    .rcon_in (round_rcon),
    .key_out (round_key)
  );

  // Next-state and datapath control; the final round writes straight to the output.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    work_key_d  = work_key_q;
    dec_key_d   = dec_key_out;
    key_valid_d = 1'b0;
    case (state_q)
      aes_pkg::ST_IDLE: begin
        if (key_valid_in) begin
          work_key_d = key_in;
          round_d    = FIRST_ROUND;
          state_d    = aes_pkg::ST_BUSY;
        end
      end
      aes_pkg::ST_BUSY: begin
        if (round_q >= LAST_ROUND) begin
          dec_key_d   = round_key;
          key_valid_d = 1'b1;
          round_d     = '0;
          state_d     = aes_pkg::ST_IDLE;
        end else begin
          work_key_d = round_key;
          round_d    = round_q + RND_W'(1);
        end
      end
      default: begin
        round_d = '0;
        state_d = aes_pkg::ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= aes_pkg::ST_IDLE;
      round_q       <= '0;
      work_key_q    <= '0;
      dec_key_out   <= '0;
      key_valid_out <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      work_key_q    <= work_key_d;
      dec_key_out   <= dec_key_d;
      key_valid_out <= key_valid_d;
    end
  end

  assign busy_out = (state_q == aes_pkg::ST_BUSY);

endmodule

// File: tb/tb_aes_dec_key_gen.sv
// Self-checking bench for aes_dec_key_gen against a GF(2^8)-derived key-schedule model.
module tb_aes_dec_key_gen;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid_in;
  logic [127:0] key_in;
  logic         busy_out;
  logic         key_valid_out;
  logic [127:0] dec_key_out;

  int total = 0;
  int bad   = 0;
  logic [7:0]   sb_model [256];
  logic [127:0] prev_dec;

  aes_dec_key_gen #(.NUM_ROUNDS(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid_in  (key_valid_in),
    .key_in        (key_in),
    .busy_out      (busy_out),
    .key_valid_out (key_valid_out),
    .dec_key_out   (dec_key_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      if (i != 0)
        for (int x = 1; x < 256; x++)
          if (gmul(8'(i), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv;
      s = s ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
            ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
      sb_model[i] = s;
    end
  endtask

  function automatic logic [127:0] model_round10(input logic [127:0] k);
    logic [31:0] w [4];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int r = 1; r <= 10; r++) begin
      t = {w[3][23:0], w[3][31:24]};
      t = {sb_model[t[31:24]], sb_model[t[23:16]], sb_model[t[15:8]], sb_model[t[7:0]]};
      t[31:24] = t[31:24] ^ rc;
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rc = xtime(rc);
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] k);
    key_in       = k;
    key_valid_in = 1'b1;
    step();
    key_valid_in = 1'b0;
    key_in       = 'x;
  endtask

  // Waits up to 20 cycles for the valid pulse; lat = -1 if it never comes.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (key_valid_out === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic run_key(input string tag, input logic [127:0] k, input logic [127:0] exp);
    int lat;
    accept(k);
    check({tag, "_busy"}, 128'(busy_out), 128'(1));
    check({tag, "_hold"}, dec_key_out, prev_dec);
    wait_valid(lat);
    check({tag, "_lat"}, 128'(lat), 128'(10));
    check({tag, "_key"}, dec_key_out, exp);
    step();
    check({tag, "_pulse1"}, 128'(key_valid_out), 128'(0));
    prev_dec = exp;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic ok;
    logic [127:0] ka, kb, kr;

    build_sbox();
    reset        = 1'b1;
    key_valid_in = 1'b0;
    key_in       = '0;
    prev_dec     = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_busy", 128'(busy_out), 128'(0));
    check("rst_kvo",  128'(key_valid_out), 128'(0));
    check("rst_dec",  dec_key_out, 128'(0));

    // Known-answer vectors
    run_key("kat_fips", 128'h2b7e151628aed2a6abf7158809cf4f3c,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_key("kat_text", 128'h5468617473206D79204B756E67204675,
            128'h28fddef86da4244accc0a4fe3b316f26);
    run_key("kat_zero", 128'h0,
            128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Keys offered while busy are dropped
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    accept(ka);
    ok = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3 || c == 9) begin
        key_valid_in = 1'b1;
        key_in       = kb;
      end else begin
        key_valid_in = 1'b0;
        key_in       = 'x;
      end
      step();
      if (c < 10 && busy_out !== 1'b1) ok = 1'b0;
      if (c < 10 && key_valid_out !== 1'b0) ok = 1'b0;
    end
    key_valid_in = 1'b0;
    check("ign_busy_hold", 128'(ok), 128'(1));
    check("ign_kvo", 128'(key_valid_out), 128'(1));
    check("ign_key", dec_key_out, model_round10(ka));
    ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (key_valid_out !== 1'b0 || busy_out !== 1'b0) ok = 1'b0;
    end
    check("ign_no_extra", 128'(ok), 128'(1));
    prev_dec = model_round10(ka);

    // Back-to-back acceptance in the valid cycle
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    accept(ka);
    wait_valid(lat);
    check("b2b_a_lat", 128'(lat), 128'(10));
    check("b2b_a_key", dec_key_out, model_round10(ka));
    accept(kb);
    check("b2b_b_busy", 128'(busy_out), 128'(1));
    check("b2b_b_hold", dec_key_out, model_round10(ka));
    wait_valid(lat);
    check("b2b_b_lat", 128'(lat), 128'(10));
    check("b2b_b_key", dec_key_out, model_round10(kb));
    prev_dec = model_round10(kb);
    step();

    // Reset mid-expansion aborts the key
    accept({$urandom, $urandom, $urandom, $urandom});
    for (int c = 1; c <= 4; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 128'(busy_out), 128'(0));
    check("abort_kvo",  128'(key_valid_out), 128'(0));
    check("abort_dec",  dec_key_out, 128'(0));
    ok = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (key_valid_out !== 1'b0) ok = 1'b0;
    end
    check("abort_no_pulse", 128'(ok), 128'(1));
    prev_dec = '0;
    kr = {$urandom, $urandom, $urandom, $urandom};
    run_key("post_abort", kr, model_round10(kr));

    // Reset wins over a simultaneous key
    reset        = 1'b1;
    key_valid_in = 1'b1;
    key_in       = {$urandom, $urandom, $urandom, $urandom};
    step();
    reset        = 1'b0;
    key_valid_in = 1'b0;
    check("rst_prio_busy", 128'(busy_out), 128'(0));
    check("rst_prio_dec",  dec_key_out, 128'(0));
    prev_dec = '0;

    // Random keys against the model
    for (int n = 0; n < 6; n++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      run_key($sformatf("rand%0d", n), kr, model_round10(kr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
